// File: rtl/mem_stage_ctrl_pkg.sv
// Shared MEM-stage definitions: load modes, controller state encodings and
// the address alignment rule.
package mem_stage_ctrl_pkg;

   localparam logic [1:0] LM_WORD   = 2'b00;
   localparam logic [1:0] LM_HALF_S = 2'b01;
   localparam logic [1:0] LM_BYTE_S = 2'b10;
   localparam logic [1:0] LM_BYTE_U = 2'b11;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Stores are always word-sized, whatever load_mode happens to hold.
   function automatic logic is_misaligned(input logic       rd,
                                          input logic       wr,
                                          input logic [1:0] mode,
                                          input logic [1:0] addr_lo);
      if (wr || (rd && mode == LM_WORD)) return addr_lo != 2'b00;
      if (rd && mode == LM_HALF_S)       return addr_lo[0];
      return 1'b0;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Word data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_stage_ctrl_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage_ctrl_load_extract.sv
// Little-endian lane select and sign/zero extension of a loaded word.
module load_extract
   import mem_stage_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  byte_off,
   input  logic [1:0]  load_mode,
   output logic [31:0] data32
);

   logic [15:0] half_v;
   logic [7:0]  byte_v;

   always_comb begin
      half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
      case (byte_off)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
   end

   always_comb begin
      data32 = '0;
      case (load_mode)
         LM_WORD:   data32 = rdata;
         LM_HALF_S: data32 = {{16{half_v[15]}}, half_v};
         LM_BYTE_S: data32 = {{24{byte_v[7]}}, byte_v};
         default:   data32 = {24'h0, byte_v};
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues variable-latency data memory accesses, stalls
// the pipeline while one is outstanding, extends load data, resolves branches.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mem_read_in,
   input  logic                    mem_write_in,
   input  logic [31:0]             alu_result_in,
   input  logic [31:0]             rt_in,
   input  logic [1:0]              load_mode_in,
   input  logic                    branch_in,
   input  logic                    zero_in,
   input  logic [31:0]             pc_in,
   mem_stage_ctrl_if.master        dmem,
   output logic                    stall,
   output logic [31:0]             mem_data_out,
   output logic                    mem_data_valid,
   output logic                    mem_fault,
   output logic                    misaligned,
   output logic                    pc_src,
   output logic [31:0]             branch_target
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [1:0]  mode_q;
   logic [1:0]  off_q;
   logic [31:0] ext_data;
   logic        op;

   assign misaligned    = is_misaligned(mem_read_in, mem_write_in, load_mode_in,
                                        alu_result_in[1:0]);
   assign op            = (mem_read_in | mem_write_in) & ~misaligned;
   assign stall         = ((state == IDLE) & op) | (state == WAIT);
   assign pc_src        = branch_in & zero_in;
   assign branch_target = pc_in;

   load_extract u_extract (
      .rdata     (dmem.dmem_rdata),
      .byte_off  (off_q),
      .load_mode (mode_q),
      .data32    (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         mode_q          <= '0;
         off_q           <= '0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         mem_data_out    <= '0;
         mem_data_valid  <= 1'b0;
         mem_fault       <= 1'b0;
      end else begin
         mem_data_valid <= 1'b0;
         mem_fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (op) begin
                  state           <= WAIT;
                  cnt             <= '0;
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= mem_write_in;
                  dmem.dmem_addr  <= {alu_result_in[31:2], 2'b00};
                  dmem.dmem_wdata <= rt_in;
                  mode_q          <= load_mode_in;
                  off_q           <= alu_result_in[1:0];
                  mem_data_out    <= '0;
               end else if (misaligned) begin
                  mem_data_out <= '0;
               end
            end
            WAIT: begin
               // Ack is tested first so it wins over a same-cycle timeout.
               if (dmem.dmem_ack) begin
                  state          <= DONE;
                  dmem.dmem_req  <= 1'b0;
                  mem_data_valid <= 1'b1;
                  mem_data_out   <= dmem.dmem_we ? '0 : ext_data;
               end else if (cnt == CNT_LAST) begin
                  state          <= DONE;
                  dmem.dmem_req  <= 1'b0;
                  mem_data_valid <= 1'b1;
                  mem_fault      <= 1'b1;
                  mem_data_out   <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
